s2p_frame_ctrl: RTL and testbench
=================================

Name: s2p_frame_ctrl

Overview:
- Frame-aligned deserializer controller for the team's serial-to-parallel shift datapath.
- Qualifies the incoming serial bit stream, counts bits into W-bit words and counts words into NWORDS-word frames.
- Strobes the parallel capture and presents each word on a valid/ready output with overflow and framing-error reporting.
- Sits between a serial line receiver and a word-wide consumer (FIFO or register file).

Parameters:
- W, 4, word width in bits; minimum 2.
- NWORDS, 8, words per frame; minimum 1.
- CW, $clog2(W) (minimum 1), bit-counter width; localparam.
- FW, $clog2(NWORDS) (minimum 1), word-index width; localparam.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  controller enable; low aborts any frame in progress.
- sin  in  1  serial data bit.
- sin_vld  in  1  sin is valid this cycle.
- sof  in  1  start of frame; qualified by sin_vld; marks bit 0 of word 0.
- pout  out  W  parallel word, first-received bit at pout[W-1].
- pout_vld  out  1  pout holds an unconsumed word.
- pout_rdy  in  1  consumer accepts the word when pout_vld and pout_rdy are both high.
- word_idx  out  FW  index of the word on pout within its frame.
- eof  out  1  word on pout is the last word of its frame.
- busy  out  1  state is SHIFT.
- overflow  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: sof arrived mid-frame.
- clr_err  in  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset (async assert, sync release): state IDLE; bit and word counters 0; shift register 0; pout 0, pout_vld 0, word_idx 0, eof 0, busy 0, overflow 0, frame_err 0.
- A bit is "accepted" when en, sin_vld and the current state permits it.
- IDLE:
  - en & sin_vld & sof -> accept the bit as bit 0 of word 0; go to SHIFT.
  - en & sin_vld & !sof -> bit ignored.
- SHIFT, each accepted bit:
  - Shift register takes {sreg[W-2:0], sin}; bit counter increments.
  - On the W-th bit (bit counter == W-1), the completed word is {sreg[W-2:0], sin}; the bit counter wraps to 0.
- Word completion:
  - Output register is free (pout_vld == 0, or pout_vld & pout_rdy in the same cycle): load pout, word_idx and eof on the next edge; pout_vld = 1. Latency from the last bit accepted to pout_vld is one cycle.
  - Output register is occupied and not being consumed: the word is dropped and overflow is set. The word counter still advances so frame alignment is kept.
  - eof = (word counter == NWORDS-1). After that word the state returns to IDLE and the counters reset.
- sin_vld low in SHIFT: hold all state (stall); no timeout.
- sof with sin_vld in SHIFT at bit 0 of word 0 is impossible by construction.
- sof with sin_vld in SHIFT at any other position:
  - frame_err is set and the partial word is discarded.
  - The bit restarts the frame as bit 0 of word 0.
  - Any word already in the output register is unaffected.
- sof coincident with the last bit of a frame: not possible, because the last bit is not bit 0. It is treated as a mid-frame sof: frame_err is set and the in-flight last word is discarded.
- en low: go to IDLE next cycle and clear the counters and shift register. The output register and its handshake keep operating.
- pout_vld clears after the handshake unless a new word loads in the same cycle.
- clr_err has priority over a same-cycle set. The set event is lost; this is documented and accepted.
- busy = (state == SHIFT).

Decomposition:
- Package s2p_pkg:
  - typedef enum logic [0:0] {S_IDLE, S_SHIFT} s2p_state_t.
  - Helper function for the clog2-minimum-1 width.
- Sub-module s2p_shreg (W):
  - Shift register with shift-enable and synchronous clear.
  - Exposes the next-word value {sreg[W-2:0], sin}.
  - Instantiated once.
- The FSM, counters, output register and flags live in the top level.

Test Plan (W=4, NWORDS=2 unless stated):
- Reset, then frame bits 1011 0110 with sof on the first bit, pout_rdy=1 -> pout 4'hB (idx 0, eof 0) one cycle after bit 3; pout 4'h6 (idx 1, eof 1) one cycle after bit 7; return to IDLE.
- Same frame with sin_vld low for 3 cycles between bits 1 and 2 -> identical words; pout_vld timing shifted by exactly 3 cycles.
- pout_rdy=0 throughout -> 4'hB held; second word dropped; overflow=1; word_idx stays 0; clr_err -> overflow=0.
- sof reasserted at bit 5 of a frame -> frame_err=1; that bit starts a new frame; the next four bits 1100 give pout 4'hC with idx 0.
- en dropped after 2 bits, then a full frame -> no word from the partial bits; the new frame decodes correctly; busy low the cycle after en falls.
- rst_n asserted mid-word with pout_vld=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/s2p_frame_ctrl_pkg.sv
// Shared types and helpers for the frame-aligned serial-to-parallel controller.
package s2p_pkg;

    typedef enum logic [0:0] {S_IDLE, S_SHIFT} s2p_state_t;

    // A one-bit counter is still needed when the range collapses to 1.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/s2p_frame_ctrl_if.sv
// Serial input side and word-wide valid/ready output side of the deserializer.
interface s2p_frame_ctrl_if
    import s2p_pkg::*;
#(
    parameter int W      = 4,
    parameter int NWORDS = 8
);
    localparam int FW = clog2_min1(NWORDS);

    logic          sin;
    logic          sin_vld;
    logic          sof;
    logic [W-1:0]  pout;
    logic          pout_vld;
    logic          pout_rdy;
    logic [FW-1:0] word_idx;
    logic          eof;

    // Producer/consumer side (bench or upstream receiver + downstream sink).
    modport master (
        output sin, sin_vld, sof, pout_rdy,
        input  pout, pout_vld, word_idx, eof
    );

    // Deserializer side.
    modport slave (
        input  sin, sin_vld, sof, pout_rdy,
        output pout, pout_vld, word_idx, eof
    );
endinterface

// File: rtl/s2p_frame_ctrl_shreg.sv
// W-bit shift register; clr together with shift_en loads the incoming bit
// into an otherwise cleared register (frame restart).
module s2p_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         clr,
    input  logic         sin,
    output logic [W-1:0] nxt_word,
    output logic [W-1:0] sreg
);
    logic [W-1:0] sreg_q, sreg_d;

    assign nxt_word = {sreg_q[W-2:0], sin};
    assign sreg     = sreg_q;

    always_comb begin
        sreg_d = sreg_q;
        if (clr && shift_en)
            sreg_d = {{(W-1){1'b0}}, sin};
        else if (clr)
            sreg_d = '0;
        else if (shift_en)
            sreg_d = nxt_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sreg_q <= '0;
        else
            sreg_q <= sreg_d;
    end
endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame-aligned deserializer controller: bit/word counting, output word
// register with valid/ready, sticky overflow and framing-error flags.
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int W      = 4,
    parameter int NWORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr_err,
    s2p_frame_ctrl_if.slave        bus,
    output logic                   busy,
    output logic                   overflow,
    output logic                   frame_err
);
    localparam int CW = clog2_min1(W);
    localparam int FW = clog2_min1(NWORDS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(W - 1);
    localparam logic [FW-1:0] WORD_LAST = FW'(NWORDS - 1);

    s2p_state_t    state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [FW-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]  pout_q, pout_d;
    logic          pvld_q, pvld_d;
    logic [FW-1:0] idx_q, idx_d;
    logic          eof_q, eof_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;

    logic          sh_en, sh_clr;
    logic          ovf_set, ferr_set;
    logic          out_free;
    logic [W-1:0]  nxt_word;
    logic [W-1:0]  sreg_unused;

    s2p_shreg #(.W(W)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (sh_en),
        .clr      (sh_clr),
        .sin      (bus.sin),
        .nxt_word (nxt_word),
        .sreg     (sreg_unused)
    );

    // The register is free if empty or being drained on this very edge.
    assign out_free = !pvld_q || bus.pout_rdy;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        wcnt_d   = wcnt_q;
        pout_d   = pout_q;
        pvld_d   = pvld_q;
        idx_d    = idx_q;
        eof_d    = eof_q;
        sh_en    = 1'b0;
        sh_clr   = 1'b0;
        ovf_set  = 1'b0;
        ferr_set = 1'b0;

        if (pvld_q && bus.pout_rdy)
            pvld_d = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
            wcnt_d  = '0;
            sh_clr  = 1'b1;
        end else if (bus.sin_vld) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.sof) begin
                        state_d = S_SHIFT;
                        sh_clr  = 1'b1;
                        sh_en   = 1'b1;
                        bcnt_d  = CW'(1);
                        wcnt_d  = '0;
                    end
                end
                S_SHIFT: begin
                    if (bus.sof) begin
                        // Mid-frame sof: drop the partial word, restart here.
                        ferr_set = 1'b1;
                        sh_clr   = 1'b1;
                        sh_en    = 1'b1;
                        bcnt_d   = CW'(1);
                        wcnt_d   = '0;
                    end else if (bcnt_q == BIT_LAST) begin
                        sh_en  = 1'b1;
                        bcnt_d = '0;
                        if (out_free) begin
                            pout_d = nxt_word;
                            idx_d  = wcnt_q;
                            eof_d  = (wcnt_q == WORD_LAST);
                            pvld_d = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                        if (wcnt_q == WORD_LAST) begin
                            state_d = S_IDLE;
                            wcnt_d  = '0;
                            sh_en   = 1'b0;
                            sh_clr  = 1'b1;
                        end else begin
                            wcnt_d = FW'(wcnt_q + 1'b1);
                        end
                    end else begin
                        sh_en  = 1'b1;
                        bcnt_d = CW'(bcnt_q + 1'b1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Clear wins over a same-cycle set; that set event is lost.
        ovf_d  = clr_err ? 1'b0 : (ovf_q  | ovf_set);
        ferr_d = clr_err ? 1'b0 : (ferr_q | ferr_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            pout_q  <= '0;
            pvld_q  <= 1'b0;
            idx_q   <= '0;
            eof_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            pout_q  <= pout_d;
            pvld_q  <= pvld_d;
            idx_q   <= idx_d;
            eof_q   <= eof_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.pout     = pout_q;
    assign bus.pout_vld = pvld_q;
    assign bus.word_idx = idx_q;
    assign bus.eof      = eof_q;
    assign busy         = (state_q == S_SHIFT);
    assign overflow     = ovf_q;
    assign frame_err    = ferr_q;
endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl at W=4, NWORDS=2; words are logged on
// handshake as {eof, word_idx, pout} with the cycle they became visible.
module tb_s2p_frame_ctrl;
    localparam int W = 4;
    localparam int NWORDS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr_err = 1'b0;
    logic busy, overflow, frame_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    int t0 = 0;
    logic [5:0] wq[$];
    int         tq[$];

    s2p_frame_ctrl_if #(.W(W), .NWORDS(NWORDS)) sif ();

    s2p_frame_ctrl #(.W(W), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_err   (clr_err),
        .bus       (sif),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && sif.pout_vld && sif.pout_rdy) begin
            wq.push_back({sif.eof, sif.word_idx[0], sif.pout});
            tq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic s);
        @(negedge clk);
        sif.sin = b;
        sif.sof = s;
        sif.sin_vld = 1'b1;
        last_acc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sif.sin_vld = 1'b0;
            sif.sof = 1'b0;
            sif.sin = 1'b0;
        end
    endtask

    task automatic send_nibble(input logic [3:0] v, input logic first_sof);
        for (int i = 3; i >= 0; i--)
            bit_in(v[i], first_sof && (i == 3));
    endtask

    initial begin
        sif.sin = 1'b0;
        sif.sin_vld = 1'b0;
        sif.sof = 1'b0;
        sif.pout_rdy = 1'b1;

        // Reset state
        #1;
        chk("rst_pout", sif.pout, 0);
        chk("rst_vld", sif.pout_vld, 0);
        chk("rst_idx", sif.word_idx, 0);
        chk("rst_eof", sif.eof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        idle(2);

        // Basic frame 1011 0110
        wq.delete(); tq.delete();
        send_nibble(4'b1011, 1'b1);
        t0 = last_acc - 3;
        send_nibble(4'b0110, 1'b0);
        idle(3);
        chk("t1_nwords", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("t1_w0", wq[0], 6'h0B);
            chk("t1_t0", tq[0] - t0, 3);
            chk("t1_w1", wq[1], 6'h36);
            chk("t1_t1", tq[1] - t0, 7);
        end
        chk("t1_busy", busy, 0);
        chk("t1_vld", sif.pout_vld, 0);

        // Same frame with a 3-cycle stall between bits 1 and 2
        wq.delete(); tq.delete();
        bit_in(1'b1, 1'b1);
        t0 = last_acc;
        bit_in(1'b0, 1'b0);
        idle(3);
        chk("t2_stall_busy", busy, 1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        send_nibble(4'b0110, 1'b0);
        idle(3);
        chk("t2_nwords", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("t2_w0", wq[0], 6'h0B);
            chk("t2_t0", tq[0] - t0, 6);
            chk("t2_w1", wq[1], 6'h36);
            chk("t2_t1", tq[1] - t0, 10);
        end

        // Overflow with consumer stalled
        sif.pout_rdy = 1'b0;
        wq.delete(); tq.delete();
        send_nibble(4'b1011, 1'b1);
        send_nibble(4'b0110, 1'b0);
        idle(3);
        chk("t3_vld", sif.pout_vld, 1);
        chk("t3_pout", sif.pout, 4'hB);
        chk("t3_idx", sif.word_idx, 0);
        chk("t3_eof", sif.eof, 0);
        chk("t3_ovf", overflow, 1);
        chk("t3_busy", busy, 0);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("t3_ovf_clr", overflow, 0);
        chk("t3_vld_held", sif.pout_vld, 1);
        sif.pout_rdy = 1'b1;
        idle(2);
        chk("t3_drained", sif.pout_vld, 0);

        // sof reasserted at bit 5 restarts the frame
        wq.delete(); tq.delete();
        send_nibble(4'b1011, 1'b1);
        bit_in(1'b0, 1'b0);
        send_nibble(4'b1100, 1'b1);
        send_nibble(4'b0011, 1'b0);
        idle(3);
        chk("t4_ferr", frame_err, 1);
        chk("t4_ovf", overflow, 0);
        chk("t4_nwords", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("t4_w0", wq[0], 6'h0B);
            chk("t4_w1", wq[1], 6'h0C);
            chk("t4_w2", wq[2], 6'h33);
        end
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("t4_ferr_clr", frame_err, 0);

        // en drop aborts a partial word
        wq.delete(); tq.delete();
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        sif.sin_vld = 1'b0;
        sif.sof = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("t5_busy_off", busy, 0);
        en = 1'b1;
        idle(1);
        send_nibble(4'b0110, 1'b1);
        send_nibble(4'b1001, 1'b0);
        idle(3);
        chk("t5_nwords", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("t5_w0", wq[0], 6'h06);
            chk("t5_w1", wq[1], 6'h39);
        end
        chk("t5_ferr", frame_err, 0);

        // Async reset mid-word with a word pending
        sif.pout_rdy = 1'b0;
        send_nibble(4'b1011, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        @(negedge clk);
        sif.sin_vld = 1'b0;
        chk("t6_vld_pre", sif.pout_vld, 1);
        chk("t6_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_pout", sif.pout, 0);
        chk("t6_vld", sif.pout_vld, 0);
        chk("t6_idx", sif.word_idx, 0);
        chk("t6_eof", sif.eof, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_ferr", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
